// File: rtl/fp_norm_seq.sv
// -----------------------------------------------------------------------------
// fp_norm_seq
//   Multi-cycle mantissa normalizer for the FP add/sub datapath. Takes the raw
//   adder result (carry-out plus sum), then either right-shifts it by one on a
//   carry or left-shifts it until the hidden bit reaches the MSB, at most STEP
//   bits per cycle. It reports the shift magnitude and direction so the add/sub
//   control block can correct the exponent. Only one operand is in flight at a
//   time.
//
// Parameters
//   MANT_W : normalized mantissa width including hidden bit (4..127)
//   STEP   : maximum left-shift bits per cycle (1, 2 or 4)
//
// Ports
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   in_valid    in   operand valid
//   in_ready    out  block can accept an operand
//   in_mant     in   adder result; [MANT_W] = carry-out, [MANT_W-1:0] = sum
//   out_valid   out  result valid
//   out_ready   in   consumer accepts result
//   out_mant    out  normalized mantissa (MSB = hidden bit unless zero)
//   norm_shift  out  shift magnitude applied (unsigned)
//   shift_right out  1 = right shift by 1 due to carry, 0 = left shift
//   out_sticky  out  LSB discarded by the right shift
//   zero        out  sum was all-zero
//
// Build option
//   FP_NORM_SEQ_PASSTHRU_EN : when defined, a result handoff and a new operand
//   acceptance may happen at the same edge (in_ready follows out_ready in DONE),
//   which removes the idle cycle between operands.
// -----------------------------------------------------------------------------
module fp_norm_seq #(
    parameter int MANT_W = 24,
    parameter int STEP   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W:0]   in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [7:0]        norm_shift,
    output logic              shift_right,
    output logic              out_sticky,
    output logic              zero
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Everything loaded at an acceptance edge, derived from the raw operand.
    typedef struct packed {
        state_e            state;
        logic [MANT_W-1:0] mant;
        logic [7:0]        shift;
        logic              sr;
        logic              sticky;
        logic              zero;
    } load_t;

    // Classify a freshly accepted adder result into carry / zero / already
    // normalized (straight to DONE) or needs left shifting (SHIFT, count 0).
    function automatic load_t classify(input logic [MANT_W:0] raw);
        load_t r;
        r.state  = ST_DONE;
        r.mant   = raw[MANT_W-1:0];
        r.shift  = 8'd0;
        r.sr     = 1'b0;
        r.sticky = 1'b0;
        r.zero   = 1'b0;
        if (raw[MANT_W]) begin
            r.mant   = raw[MANT_W:1];
            r.sticky = raw[0];
            r.shift  = 8'd1;
            r.sr     = 1'b1;
        end else if (raw[MANT_W-1:0] == {MANT_W{1'b0}}) begin
            r.mant = {MANT_W{1'b0}};
            r.zero = 1'b1;
        end else if (raw[MANT_W-1]) begin
            r.state = ST_DONE;
        end else begin
            r.state = ST_SHIFT;
        end
        return r;
    endfunction

    // Leading zeros among the top STEP bits, capped at STEP. Stopping at the
    // first one guarantees a shift never pushes the hidden bit out of the MSB.
    function automatic logic [2:0] top_lz(input logic [MANT_W-1:0] m);
        logic [2:0] k;
        logic       found;
        k     = 3'(STEP);
        found = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (!found && m[MANT_W-1-i]) begin
                k     = 3'(i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return k;
    endfunction

    state_e            state_q, state_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [7:0]        shift_q, shift_d;
    logic              sr_q, sr_d;
    logic              sticky_q, sticky_d;
    logic              zero_q, zero_d;

    logic              accept_s;
    load_t             load_s;
    logic [2:0]        k_s;
    logic [MANT_W-1:0] shifted_s;

    assign accept_s  = in_valid && in_ready;
    assign load_s    = classify(in_mant);
    assign k_s       = top_lz(mant_q);
    assign shifted_s = mant_q << k_s;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mant_q   <= {MANT_W{1'b0}};
            shift_q  <= 8'd0;
            sr_q     <= 1'b0;
            sticky_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mant_q   <= mant_d;
            shift_q  <= shift_d;
            sr_q     <= sr_d;
            sticky_q <= sticky_d;
            zero_q   <= zero_d;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_d  = state_q;
        mant_d   = mant_q;
        shift_d  = shift_q;
        sr_d     = sr_q;
        sticky_d = sticky_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d  = load_s.state;
                    mant_d   = load_s.mant;
                    shift_d  = load_s.shift;
                    sr_d     = load_s.sr;
                    sticky_d = load_s.sticky;
                    zero_d   = load_s.zero;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // shift_q doubles as the running left-shift count here.
                mant_d  = shifted_s;
                shift_d = shift_q + {5'd0, k_s};
                if (shifted_s[MANT_W-1]) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    // accept_s can only be set here when pass-through is built in.
                    if (accept_s) begin
                        state_d  = load_s.state;
                        mant_d   = load_s.mant;
                        shift_d  = load_s.shift;
                        sr_d     = load_s.sr;
                        sticky_d = load_s.sticky;
                        zero_d   = load_s.zero;
                    end else begin
                        state_d  = ST_IDLE;
                        sr_d     = 1'b0;
                        sticky_d = 1'b0;
                        zero_d   = 1'b0;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        out_valid = (state_q == ST_DONE);
`ifdef FP_NORM_SEQ_PASSTHRU_EN
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
`else
        in_ready  = (state_q == ST_IDLE);
`endif
    end

    assign out_mant    = mant_q;
    assign norm_shift  = shift_q;
    assign shift_right = sr_q;
    assign out_sticky  = sticky_q;
    assign zero        = zero_q;

endmodule
